// File: rtl/timer_cmd_tx.sv
// Command initiator for the one-hot serial timer: frames a 4-bit delay behind the 1101 start pattern,
// waits for done, pulses ack, then holds an idle gap. Optional watchdog: `define TIMER_CMD_TX_WATCHDOG_EN.
module timer_cmd_tx #(
   parameter int GAP_CYCLES      = 2,
   parameter int CYCLES_PER_UNIT = 1000,
   parameter int WD_SLACK        = 16,
   parameter int WD_W            = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_delay,
   output logic       d,
   input  logic       done,
   output logic       ack,
   output logic       busy,
   output logic       complete,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_WAIT_DONE,
      S_ACK,
      S_GAP
   } state_t;

   localparam logic [3:0] START_PAT = 4'b1101;

   state_t     state_q, state_d;
   logic [3:0] sreg_q, sreg_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] idx_inc;
   logic [7:0] gap_q, gap_d;
   logic       d_q, d_d;
   logic       ack_q, ack_d;
   logic       err_q, err_d;
   logic       wd_expire;

`ifdef TIMER_CMD_TX_WATCHDOG_EN
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic [WD_W-1:0] wd_limit;

   assign wd_limit = (WD_W'(sreg_q) + WD_W'(1)) * WD_W'(CYCLES_PER_UNIT) + WD_W'(WD_SLACK);

   // Count is the number of completed WAIT_DONE cycles; it restarts on every entry.
   always_comb begin
      wd_cnt_d  = '0;
      wd_expire = 1'b0;
      if (state_q == S_WAIT_DONE) begin
         wd_cnt_d  = wd_cnt_q + WD_W'(1);
         wd_expire = (wd_cnt_d == wd_limit);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) wd_cnt_q <= '0;
      else         wd_cnt_q <= wd_cnt_d;
   end
`else
   assign wd_expire = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         d_q     <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         d_q     <= d_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      d_d     = 1'b0;
      ack_d   = 1'b0;
      err_d   = err_q;
      idx_inc = idx_q + 2'd1;
      // NOTE: d and ack are registered, so each is computed from the bit the next state will present,
      // which puts the first start bit on the wire in the cycle right after the handshake edge.
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               sreg_d  = cmd_delay;
               idx_d   = 2'd0;
               err_d   = 1'b0;
               state_d = S_PRE;
               d_d     = START_PAT[3];
            end
         end
         S_PRE: begin
            if (idx_q == 2'd3) begin
               idx_d   = 2'd0;
               state_d = S_DATA;
               d_d     = sreg_q[3];
            end else begin
               idx_d = idx_inc;
               d_d   = START_PAT[~idx_inc];
            end
         end
         S_DATA: begin
            if (idx_q == 2'd3) begin
               state_d = S_WAIT_DONE;
            end else begin
               idx_d = idx_inc;
               d_d   = sreg_q[~idx_inc];
            end
         end
         S_WAIT_DONE: begin
            if (done) begin
               state_d = S_ACK;
               ack_d   = 1'b1;
            end else if (wd_expire) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ACK: begin
            gap_d   = 8'(GAP_CYCLES - 1);
            state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_q == 8'd0) state_d = S_IDLE;
            else               gap_d   = gap_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      d         = d_q;
      ack       = ack_q;
      complete  = ack_q;
      err       = err_q;
   end

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Directed self-checking bench for timer_cmd_tx; covers the watchdog when TIMER_CMD_TX_WATCHDOG_EN is defined.
module tb_timer_cmd_tx;

   logic       clk = 1'b0;
   logic       resetn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_delay;
   logic       d;
   logic       done;
   logic       ack;
   logic       busy;
   logic       complete;
   logic       err;

   int checks   = 0;
   int failures = 0;

   timer_cmd_tx #(
      .GAP_CYCLES     (2),
      .CYCLES_PER_UNIT(10),
      .WD_SLACK       (2),
      .WD_W           (16)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_delay(cmd_delay),
      .d        (d),
      .done     (done),
      .ack      (ack),
      .busy     (busy),
      .complete (complete),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      cmd_valid = 1'b0;
      cmd_delay = 4'b0000;
      done      = 1'b0;
      repeat (2) tick();
      checks++;
      if ({d, ack, complete, cmd_ready, busy, err} !== 6'b000100) begin
         failures++;
         $display("FAIL reset_outputs: got {d,ack,complete,ready,busy,err}=%b expected 000100",
                  {d, ack, complete, cmd_ready, busy, err});
      end
      cmd_valid = 1'b1;
      cmd_delay = 4'b1111;
      tick();
      checks++;
      if ({busy, cmd_ready, d} !== 3'b010) begin
         failures++;
         $display("FAIL reset_no_accept: got {busy,ready,d}=%b expected 010", {busy, cmd_ready, d});
      end
      cmd_valid = 1'b0;
      resetn    = 1'b1;
      tick();
      checks++;
      if ({busy, cmd_ready, d, err} !== 4'b0100) begin
         failures++;
         $display("FAIL reset_release_idle: got {busy,ready,d,err}=%b expected 0100",
                  {busy, cmd_ready, d, err});
      end
   endtask

   task automatic test_frame_1010();
      logic [7:0] exp_bits;
      exp_bits  = 8'b1101_1010;
      cmd_delay = 4'b1010;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (d !== exp_bits[7-i] || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL frame_1010 bit %0d: got d=%b ready=%b busy=%b expected d=%b ready=0 busy=1",
                     i, d, cmd_ready, busy, exp_bits[7-i]);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({d, ack, busy, cmd_ready} !== 4'b0010) begin
            failures++;
            $display("FAIL frame_1010_tail %0d: got {d,ack,busy,ready}=%b expected 0010",
                     i, {d, ack, busy, cmd_ready});
         end
         if (i < 2) tick();
      end
   endtask

   task automatic test_done_ack();
      done = 1'b1;
      checks++;
      if (ack !== 1'b0) begin
         failures++;
         $display("FAIL ack_early: got ack=%b expected 0", ack);
      end
      tick();
      done = 1'b0;
      checks++;
      if ({ack, complete, d} !== 3'b110) begin
         failures++;
         $display("FAIL ack_pulse: got {ack,complete,d}=%b expected 110", {ack, complete, d});
      end
      tick();
      checks++;
      if ({ack, complete, cmd_ready, busy, d} !== 5'b00010) begin
         failures++;
         $display("FAIL ack_gap1: got {ack,complete,ready,busy,d}=%b expected 00010",
                  {ack, complete, cmd_ready, busy, d});
      end
      tick();
      checks++;
      if ({cmd_ready, busy, d} !== 3'b010) begin
         failures++;
         $display("FAIL ack_gap2: got {ready,busy,d}=%b expected 010", {cmd_ready, busy, d});
      end
      tick();
      checks++;
      if ({cmd_ready, busy, d} !== 3'b100) begin
         failures++;
         $display("FAIL ready_after_gap: got {ready,busy,d}=%b expected 100", {cmd_ready, busy, d});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_a;
      logic [7:0] exp_b;
      exp_a     = 8'b1101_0000;
      exp_b     = 8'b1101_1111;
      cmd_delay = 4'b0000;
      cmd_valid = 1'b1;
      tick();
      cmd_delay = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (d !== exp_a[7-i] || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first bit %0d: got d=%b ready=%b expected d=%b ready=0",
                     i, d, cmd_ready, exp_a[7-i]);
         end
         tick();
      end
      tick();
      checks++;
      if ({cmd_ready, busy} !== 2'b01) begin
         failures++;
         $display("FAIL b2b_wait_held: got {ready,busy}=%b expected 01", {cmd_ready, busy});
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (ack !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ack: got ack=%b expected 1", ack);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({cmd_ready, d} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_gap %0d: got {ready,d}=%b expected 00", i, {cmd_ready, d});
         end
      end
      tick();
      checks++;
      if ({cmd_ready, busy, d} !== 3'b100) begin
         failures++;
         $display("FAIL b2b_idle: got {ready,busy,d}=%b expected 100", {cmd_ready, busy, d});
      end
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (d !== exp_b[7-i] || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second bit %0d: got d=%b ready=%b expected d=%b ready=0",
                     i, d, cmd_ready, exp_b[7-i]);
         end
         tick();
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      repeat (3) tick();
      checks++;
      if ({cmd_ready, busy} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_end: got {ready,busy}=%b expected 10", {cmd_ready, busy});
      end
   endtask

   task automatic test_reset_mid_data();
      cmd_delay = 4'b0110;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (6) tick();
      checks++;
      if (d !== 1'b1) begin
         failures++;
         $display("FAIL mid_data_bit2: got d=%b expected 1", d);
      end
      resetn = 1'b0;
      tick();
      checks++;
      if ({d, busy, cmd_ready, ack, err} !== 5'b00100) begin
         failures++;
         $display("FAIL mid_data_reset: got {d,busy,ready,ack,err}=%b expected 00100",
                  {d, busy, cmd_ready, ack, err});
      end
      resetn = 1'b1;
      tick();
      checks++;
      if ({d, busy, cmd_ready} !== 3'b001) begin
         failures++;
         $display("FAIL mid_data_after: got {d,busy,ready}=%b expected 001", {d, busy, cmd_ready});
      end
   endtask

`ifdef TIMER_CMD_TX_WATCHDOG_EN
   task automatic test_watchdog();
      cmd_delay = 4'b0001;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (8) tick();
      // Limit is (1+1)*10+2 = 22 WAIT_DONE cycles.
      for (int i = 0; i < 22; i++) begin
         checks++;
         if ({err, ack, busy} !== 3'b001) begin
            failures++;
            $display("FAIL wd_waiting %0d: got {err,ack,busy}=%b expected 001", i, {err, ack, busy});
         end
         tick();
      end
      checks++;
      if ({err, ack, cmd_ready, busy} !== 4'b1010) begin
         failures++;
         $display("FAIL wd_timeout: got {err,ack,ready,busy}=%b expected 1010",
                  {err, ack, cmd_ready, busy});
      end
      tick();
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL wd_sticky: got err=%b expected 1", err);
      end
      cmd_delay = 4'b0000;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({err, busy} !== 2'b01) begin
         failures++;
         $display("FAIL wd_clear_on_accept: got {err,busy}=%b expected 01", {err, busy});
      end
      repeat (8) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if ({ack, err} !== 2'b10) begin
         failures++;
         $display("FAIL wd_normal_ack: got {ack,err}=%b expected 10", {ack, err});
      end
      repeat (3) tick();
   endtask
`else
   task automatic test_no_watchdog();
      cmd_delay = 4'b0001;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      repeat (8) tick();
      for (int i = 0; i < 40; i++) begin
         checks++;
         if ({err, ack, busy} !== 3'b001) begin
            failures++;
            $display("FAIL nowd_waiting %0d: got {err,ack,busy}=%b expected 001", i, {err, ack, busy});
         end
         tick();
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if ({ack, err} !== 2'b10) begin
         failures++;
         $display("FAIL nowd_ack: got {ack,err}=%b expected 10", {ack, err});
      end
      repeat (3) tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL time_limit: simulation exceeded its time budget");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_frame_1010();
      test_done_ack();
      test_back_to_back();
      test_reset_mid_data();
`ifdef TIMER_CMD_TX_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_cmd_tx.md
Name: timer_cmd_tx

Overview:
- Initiator for the one-hot serial timer FSM. Accepts a 4-bit delay command over a valid/ready handshake.
- Serializes the start pattern 1101 and then the delay bits MSB-first on the timer's d input.
- Waits for the timer's done, pulses ack, then guarantees an idle gap before the next command.
- Sits between the host command path and the timer block, driving its d/ack inputs and observing its done output.

Parameters:
- GAP_CYCLES, 2, idle cycles with d=0 after ack before cmd_ready is reasserted (min 1)
- CYCLES_PER_UNIT, 1000, timer cycles per delay unit; used only by the watchdog
- WD_SLACK, 16, extra cycles tolerated beyond the nominal count before timeout (watchdog only)
- WD_W, 16, watchdog counter width; must hold 16*CYCLES_PER_UNIT+WD_SLACK

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous active-low reset
- cmd_valid  input  1  host command valid
- cmd_ready  output  1  block can accept a command
- cmd_delay  input  4  delay value, captured on handshake
- d  output  1  serial line to timer, registered
- done  input  1  timer done (high while timer is in Wait)
- ack  output  1  acknowledge to timer, registered one-cycle pulse
- busy  output  1  high from accept until return to IDLE
- complete  output  1  one-cycle pulse in the cycle ack is driven
- err  output  1  sticky watchdog timeout flag; tied 0 when feature is absent

Behaviour:
- Reset (resetn=0 at a clock edge), from any state including mid-frame:
  - state=IDLE; d=0, ack=0, complete=0, err=0, busy=0, cmd_ready=1.
  - A reset mid-frame leaves the timer partially loaded. Recovery is by the timer's own reset, outside this block.
- States: IDLE, PRE, DATA, WAIT_DONE, ACK, GAP.
- IDLE:
  - cmd_ready=1, d=0.
  - Handshake when cmd_valid&cmd_ready at edge T: capture cmd_delay into sreg, clear bit index, busy=1 from T+1, go PRE.
  - cmd_valid while not ready is ignored. The host holds it.
- PRE: d over cycles T+1..T+4 = 1,1,0,1. Then go DATA.
- DATA: d over cycles T+5..T+8 = sreg[3], sreg[2], sreg[1], sreg[0]. Then go WAIT_DONE.
- WAIT_DONE:
  - d=0.
  - If done==1 is sampled at an edge, go ACK. The ack output is high exactly the following cycle.
  - done is ignored in every other state.
- ACK:
  - ack=1 and complete=1 for exactly 1 cycle, d=0.
  - Then go GAP, loading the gap counter with GAP_CYCLES-1.
- GAP:
  - d=0, ack=0; count down.
  - At 0 go IDLE; cmd_ready=1 and busy=0 on the next cycle.
- Latency:
  - Accept to last data bit: 8 cycles.
  - done sampled to ack: 1 cycle.
  - ack to next cmd_ready: GAP_CYCLES+1 cycles.
- cmd_ready is 0 in every state other than IDLE. There is no command queueing.
- Bit index and gap counter are 2-bit and 8-bit respectively; they saturate and never wrap inside a state.
- done high already on entry to WAIT_DONE (stale) is honoured. The bench must not present it early.

Optional Feature:
- Macro TIMER_CMD_TX_WATCHDOG_EN.
- Defined:
  - A WD_W-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - Limit = (sreg+1)*CYCLES_PER_UNIT + WD_SLACK, computed at WD_W width.
  - If the count reaches the limit with no done: set err=1, go IDLE directly with no ack, busy=0.
  - err stays set until reset or the next accepted command.
  - If done and the limit occur in the same cycle, done wins and err stays 0.
- Undefined: no counter is instantiated; err is constant 0; WAIT_DONE waits indefinitely.

Test Plan:
- Reset hold then release:
  - Required: d=0, ack=0, cmd_ready=1, busy=0, err=0.
  - Then assert cmd_valid with resetn=0: no accept.
- Accept cmd_delay=4'b1010 at edge T:
  - Required: d over T+1..T+8 = 1,1,0,1,1,0,1,0; cmd_ready=0 throughout.
  - d=0 afterwards.
- In WAIT_DONE, raise done at cycle W:
  - Required: ack=1 and complete=1 at W+1 only.
  - With GAP_CYCLES=2, cmd_ready=1 at W+4.
- Back-to-back commands 4'b0000 then 4'b1111 with cmd_valid held high:
  - Required: second accept only after the gap; d stays 0 for ≥GAP_CYCLES between frames.
  - Second frame d = 1,1,0,1,1,1,1,1.
- Pull resetn low during DATA (third data bit):
  - Required: next cycle state IDLE, d=0, busy=0, cmd_ready=1.
- Watchdog build, CYCLES_PER_UNIT=10, WD_SLACK=2, delay=1, done never asserted:
  - Required: err=1 after 22 WAIT_DONE cycles, no ack, cmd_ready=1.
  - err clears on the next accept.
